ahb_sram_slave: RTL and testbench
=================================

// Module: ahb_sram_slave
// PURPOSE
//  AHB-Lite responder: word-addressed on-chip SRAM that plugs into one slave port of AHB_bus.
//  Accepts address phases routed by the bus arbiter, inserts WAIT_STATES wait cycles,
//  performs byte/half/word reads and writes, and signals a two-cycle ERROR on bad accesses.
//  Port fields map 1:1 onto mas_send_type (inputs) and slv_send_type (outputs).
// PARAMETERS
//  DEPTH        1024   number of 32-bit words (power of 2, >=2)
//  BASE_ADDR    32'h0  byte address of word 0; legal range BASE_ADDR .. BASE_ADDR+4*DEPTH-1
//  WAIT_STATES  0      hreadyout-low cycles per OKAY data phase (0..15)
// PORTS
//  hclk       in   1   clock, all logic on rising edge
//  hreset     in   1   synchronous reset, active-high
//  hsel       in   1   slave select from arbiter (hsel_slave_N)
//  haddr      in   32  byte address
//  htrans     in   2   00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//  hwrite     in   1   1 = write
//  hsize      in   3   000 byte, 001 half, 010 word; others illegal
//  hburst     in   3   burst type, informational only (not checked)
//  hprot      in   4   ignored
//  hmastlock  in   1   ignored
//  hwdata     in   32  write data, valid in data phase
//  hreadyout  out  1   transfer complete / slave ready
//  hrdata     out  32  read data, valid when hreadyout=1 in a read data phase
//  hresp      out  1   0 OKAY, 1 ERROR
// BEHAVIOUR
//  Reset (hreset=1 at edge): state IDLE, hreadyout=1, hresp=0, hrdata=0, wait counter=0,
//   pending-phase regs cleared. SRAM contents NOT reset. Reset mid-transfer aborts it; a
//   write whose completing edge coincides with reset is dropped.
//  Accept: address phase taken at edge when hsel=1 & htrans[1]=1 & hreadyout=1. IDLE/BUSY or
//   hsel=0 with hreadyout=1 -> no action, next cycle hreadyout=1, hresp=0 (zero-wait OKAY).
//  Error check on accept: off=haddr-BASE_ADDR; error if off>=4*DEPTH, or hsize>2, or misaligned
//   (half: haddr[0]!=0; word: haddr[1:0]!=0). Error access never touches SRAM.
//  FSM (registered outputs):
//   IDLE  : hreadyout=1,hresp=0. accept&err->ERR1; accept&WAIT_STATES>0->WAIT (cnt=WAIT_STATES-1);
//           accept&WAIT_STATES==0->DATA; else stay.
//   WAIT  : hreadyout=0,hresp=0. cnt==0->DATA, else cnt--. Inputs other than hwdata ignored.
//   DATA  : hreadyout=1,hresp=0; completing cycle. Write commits at this edge using hwdata and
//           byte lanes from registered haddr[1:0]/hsize. Next state as IDLE (pipelined accept).
//   ERR1  : hreadyout=0,hresp=1 -> ERR2.
//   ERR2  : hreadyout=1,hresp=1; may accept next phase (same rules as IDLE).
//  Read data: hrdata loaded at the edge entering DATA with full word mem[idx]
//   (idx=off[$clog2(DEPTH)+1:2]); master selects lanes. hrdata holds its value otherwise.
//  Hazard: read address phase accepted while a write is in DATA to same idx -> hrdata must
//   reflect the write (byte-merge forwarding of hwdata into the read word).
//  Latency: OKAY transfer = 1+WAIT_STATES cycles after accept; ERROR always 2 cycles.
//  Back-to-back SEQ bursts sustain 1 transfer/cycle when WAIT_STATES=0.
// TESTING
//  1 WAIT_STATES=0: write word 0xDEADBEEF @BASE+0x10, then read -> hreadyout never low,
//    hrdata=0xDEADBEEF, hresp=0.
//  2 Back-to-back NONSEQ write 0x11223344 @0x20 then read @0x20 next cycle -> forwarded
//    hrdata=0x11223344 (no stale data).
//  3 Byte write 0xAA @0x21 over 0x00000000, half write 0xBBCC @0x22 -> word read 0xBBCCAA00.
//  4 WAIT_STATES=3: read -> hreadyout low exactly 3 cycles, data on 4th; 4-beat INCR burst
//    completes in 16 cycles.
//  5 Access @BASE+4*DEPTH, @0x02 word, hsize=3 -> each: hresp=1 with hreadyout 0 then 1;
//    target word unchanged on readback.
//  6 Assert hreset during WAIT of a write -> next cycle hreadyout=1,hresp=0,hrdata=0; word
//    unchanged; IDLE transfers give zero-wait OKAY.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite word-addressed SRAM responder with wait states and two-cycle ERROR
module ahb_sram_slave #(
    parameter int unsigned DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [3:0]  hprot,
    input  logic        hmastlock,
    input  logic [31:0] hwdata,
    output logic        hreadyout,
    output logic [31:0] hrdata,
    output logic        hresp
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q;
    logic [1:0]    lane_q;
    logic [1:0]    size_q;
    logic          write_q;
    logic [31:0]   hrdata_q;
    logic [31:0]   mem_q [DEPTH];

    logic [31:0]   off;
    logic [AW-1:0] acc_idx;
    logic          accept;
    logic          acc_err;
    logic [3:0]    wr_be;
    logic [AW-1:0] rd_idx;
    logic          fwd_hit;
    logic          rd_load;
    logic [31:0]   rd_word;
    logic          unused_inputs;

    assign unused_inputs = ^{hburst, hprot, hmastlock};

    assign off       = haddr - BASE_ADDR;
    assign acc_idx   = off[AW+1:2];
    assign hreadyout = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2);
    assign hresp     = (state_q == S_ERR1) || (state_q == S_ERR2);
    assign hrdata    = hrdata_q;
    assign accept    = hsel && htrans[1] && hreadyout;

    // Offsets below BASE_ADDR wrap to huge values and fall out of range as well.
    assign acc_err = (|(off >> (AW + 2)))
                  || (hsize > 3'd2)
                  || ((hsize == 3'd1) && haddr[0])
                  || ((hsize == 3'd2) && (haddr[1:0] != 2'b00));

    always_comb begin
        wr_be = 4'b1111;
        case (size_q)
            2'd0:    wr_be = 4'b0001 << lane_q;
            2'd1:    wr_be = lane_q[1] ? 4'b1100 : 4'b0011;
            default: wr_be = 4'b1111;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DATA, S_ERR2: begin
                state_d = S_IDLE;
                if (accept) begin
                    if (acc_err) begin
                        state_d = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase
    end

    // A read accepted on the edge that commits a write to the same word sees the merged bytes.
    always_comb begin
        rd_idx  = (state_q == S_WAIT) ? idx_q : acc_idx;
        fwd_hit = (state_q == S_DATA) && write_q && (idx_q == rd_idx);
        rd_load = (state_d == S_DATA) && ((state_q == S_WAIT) ? !write_q : !hwrite);
        rd_word = mem_q[rd_idx];
        for (int b = 0; b < 4; b++) begin
            if (fwd_hit && wr_be[b]) begin
                rd_word[8*b +: 8] = hwdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            idx_q    <= '0;
            lane_q   <= 2'd0;
            size_q   <= 2'd0;
            write_q  <= 1'b0;
            hrdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q   <= acc_idx;
                lane_q  <= haddr[1:0];
                size_q  <= hsize[1:0];
                write_q <= hwrite;
            end
            if (rd_load) begin
                hrdata_q <= rd_word;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (!hreset && (state_q == S_DATA) && write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem_q[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - randomized self-checking bench for ahb_sram_slave (0 and 3 wait states)
module tb_ahb_sram_slave;
    localparam int          DEPTH  = 64;
    localparam logic [31:0] BASE   = 32'h0000_1000;
    localparam logic [1:0]  T_IDLE = 2'b00;
    localparam logic [1:0]  T_NSEQ = 2'b10;
    localparam logic [1:0]  T_SEQ  = 2'b11;

    // kind: 0 real transfer, 1 IDLE/BUSY cycle, 2 NONSEQ with hsel low
    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [1:0]  trans;
    } xfer_t;

    logic        hclk = 1'b0;
    logic        hreset, hsel, hwrite, hmastlock, use3;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic        rdy0, rdy3, resp0, resp3, rdy, rsp;
    logic [31:0] rd0, rd3, rdata;

    always #5 hclk = ~hclk;

    ahb_sram_slave #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0)) dut0 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel & ~use3), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock),
        .hwdata(hwdata), .hreadyout(rdy0), .hrdata(rd0), .hresp(resp0)
    );

    ahb_sram_slave #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(3)) dut3 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel & use3), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock),
        .hwdata(hwdata), .hreadyout(rdy3), .hrdata(rd3), .hresp(resp3)
    );

    assign rdy   = use3 ? rdy3 : rdy0;
    assign rsp   = use3 ? resp3 : resp0;
    assign rdata = use3 ? rd3 : rd0;

    xfer_t       q[$];
    logic [31:0] ref_mem [2][DEPTH];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cur_ws = 0;
    int          span;

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit xfer_err(xfer_t t);
        logic [31:0] off = t.addr - BASE;
        if (off >= 32'(4 * DEPTH)) return 1'b1;
        if (t.size > 3'd2) return 1'b1;
        return (t.addr % (32'd1 << t.size)) != 32'd0;
    endfunction

    function automatic int xfer_idx(xfer_t t);
        return int'((t.addr - BASE) >> 2);
    endfunction

    task automatic model_write(xfer_t t);
        int w  = xfer_idx(t);
        int nb = 1 << t.size;
        for (int k = 0; k < nb; k++) begin
            int b = int'(t.addr[1:0]) + k;
            ref_mem[use3][w][8*b +: 8] = t.wdata[8*b +: 8];
        end
    endtask

    task automatic push(int kind, logic [31:0] addr, logic wr, logic [2:0] size,
                        logic [31:0] wdata, logic [1:0] trans);
        xfer_t t;
        t.kind = kind; t.addr = addr; t.wr = wr; t.size = size; t.wdata = wdata; t.trans = trans;
        q.push_back(t);
    endtask

    // Pipelined master: presents the next address phase whenever the slave is ready.
    task automatic run_seq(output int span_o);
        xfer_t dp;
        bit    dp_v = 1'b0;
        bit    all_x = 1'b1;
        int    waits = 0, iter = 0, done_iter = 0, i = 0, exp_span = 0;
        foreach (q[j]) begin
            if (q[j].kind != 0) all_x = 1'b0;
            else exp_span += xfer_err(q[j]) ? 2 : 1 + cur_ws;
        end
        while ((i < q.size() || dp_v) && iter < 4000) begin
            @(negedge hclk);
            iter++;
            hwdata = (dp_v && dp.wr) ? dp.wdata : $urandom;
            if (dp_v) begin
                check_eq("hresp", 32'(rsp), 32'(xfer_err(dp)));
                if (rdy) begin
                    if (xfer_err(dp)) begin
                        check_eq("err_waits", 32'(waits), 32'd1);
                    end else begin
                        check_eq("waits", 32'(waits), 32'(cur_ws));
                        if (dp.wr) model_write(dp);
                        else check_eq("rdata", rdata, ref_mem[use3][xfer_idx(dp)]);
                    end
                    done_iter = iter;
                end else begin
                    waits++;
                end
            end else begin
                check_eq("idle_rdy", 32'(rdy), 32'd1);
                check_eq("idle_resp", 32'(rsp), 32'd0);
            end
            if (rdy) begin
                dp_v  = 1'b0;
                waits = 0;
                if (i < q.size()) begin
                    dp     = q[i];
                    i++;
                    hsel   = (dp.kind != 2);
                    haddr  = dp.addr;
                    hwrite = dp.wr;
                    hsize  = dp.size;
                    htrans = (dp.kind == 1) ? 2'($urandom_range(0, 1)) : dp.trans;
                    hburst = 3'($urandom_range(0, 7));
                    hprot  = 4'($urandom_range(0, 15));
                    dp_v   = (dp.kind == 0);
                end else begin
                    hsel   = 1'b0;
                    htrans = T_IDLE;
                end
            end
        end
        check_eq("timeout_left", 32'(q.size() - i) + 32'(dp_v), 32'd0);
        span_o = done_iter - 1;
        if (all_x) check_eq("span", 32'(span_o), 32'(exp_span));
        q.delete();
        hsel   = 1'b0;
        htrans = T_IDLE;
    endtask

    task automatic reset_mid(logic [31:0] addr, logic [31:0] wdata);
        @(negedge hclk);
        check_eq("pre_rst_rdy", 32'(rdy), 32'd1);
        hsel = 1'b1; haddr = addr; hwrite = 1'b1; hsize = 3'd2; htrans = T_NSEQ;
        @(negedge hclk);
        hsel = 1'b0; htrans = T_IDLE; hwdata = wdata; hreset = 1'b1;
        @(negedge hclk);
        hreset = 1'b0;
        check_eq("rst_rdy", 32'(rdy), 32'd1);
        check_eq("rst_resp", 32'(rsp), 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
    endtask

    task automatic init_mem();
        for (int w = 0; w < DEPTH; w++)
            push(0, BASE + 32'(4 * w), 1'b1, 3'd2, $urandom, (w == 0) ? T_NSEQ : T_SEQ);
        run_seq(span);
    endtask

    task automatic error_cases();
        push(0, BASE + 32'(4 * DEPTH), 1'b1, 3'd2, 32'hBAD0_0001, T_NSEQ);
        push(0, BASE + 32'h02,         1'b1, 3'd2, 32'hBAD0_0002, T_NSEQ);
        push(0, BASE + 32'h10,         1'b1, 3'd3, 32'hBAD0_0003, T_NSEQ);
        push(0, BASE - 32'h4,          1'b1, 3'd2, 32'hBAD0_0004, T_NSEQ);
        push(0, BASE + 32'h11,         1'b0, 3'd1, 32'h0,         T_NSEQ);
        push(0, BASE + 32'h00,         1'b0, 3'd2, 32'h0,         T_NSEQ);
        push(0, BASE + 32'h10,         1'b0, 3'd2, 32'h0,         T_NSEQ);
        run_seq(span);
    endtask

    task automatic rand_run(int n);
        repeat (n) begin
            int          r = $urandom_range(0, 15);
            int          lane = $urandom_range(0, 3);
            int          word = $urandom_range(0, 7);
            logic [2:0]  sz = ($urandom_range(0, 15) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            logic [31:0] a;
            if (sz <= 3'd2 && $urandom_range(0, 3) != 0) lane = lane & ~((1 << sz) - 1);
            a = BASE + 32'(4 * word + lane);
            case ($urandom_range(0, 19))
                0: a = BASE + 32'(4 * DEPTH + 4 * word);
                1: a = BASE - 32'd4;
                default: ;
            endcase
            if (r < 2)       push(1, a, 1'b0, sz, 32'h0, T_IDLE);
            else if (r < 3)  push(2, a, 1'($urandom_range(0, 1)), sz, $urandom, T_NSEQ);
            else             push(0, a, 1'($urandom_range(0, 1)), sz, $urandom,
                                  ($urandom_range(0, 1) != 0) ? T_SEQ : T_NSEQ);
        end
        run_seq(span);
    endtask

    initial begin
        hreset = 1'b1; hsel = 1'b0; haddr = 32'h0; htrans = T_IDLE; hwrite = 1'b0;
        hsize = 3'd0; hburst = 3'd0; hprot = 4'd0; hmastlock = 1'b0; hwdata = 32'h0; use3 = 1'b0;
        repeat (3) @(negedge hclk);
        hreset = 1'b0;
        check_eq("reset_rdy0", 32'(rdy0), 32'd1);
        check_eq("reset_resp0", 32'(resp0), 32'd0);
        check_eq("reset_rdata0", rd0, 32'd0);
        check_eq("reset_rdy3", 32'(rdy3), 32'd1);
        check_eq("reset_resp3", 32'(resp3), 32'd0);
        check_eq("reset_rdata3", rd3, 32'd0);

        use3 = 1'b0; cur_ws = 0;
        init_mem();
        push(0, BASE + 32'h10, 1'b1, 3'd2, 32'hDEADBEEF, T_NSEQ);
        push(0, BASE + 32'h10, 1'b0, 3'd2, 32'h0,        T_NSEQ);
        run_seq(span);
        push(0, BASE + 32'h20, 1'b1, 3'd2, 32'h11223344, T_NSEQ);
        push(0, BASE + 32'h20, 1'b0, 3'd2, 32'h0,        T_NSEQ);
        run_seq(span);
        push(0, BASE + 32'h20, 1'b1, 3'd2, 32'h00000000, T_NSEQ);
        push(0, BASE + 32'h21, 1'b1, 3'd0, 32'h0000AA00, T_NSEQ);
        push(0, BASE + 32'h22, 1'b1, 3'd1, 32'hBBCC0000, T_NSEQ);
        push(0, BASE + 32'h20, 1'b0, 3'd2, 32'h0,        T_NSEQ);
        run_seq(span);
        error_cases();
        push(0, BASE + 32'h30, 1'b1, 3'd2, 32'h5A5A1234, T_NSEQ);
        push(0, BASE + 32'h30, 1'b0, 3'd2, 32'h0,        T_NSEQ);
        run_seq(span);
        reset_mid(BASE + 32'h30, 32'hCAFEF00D);
        push(1, BASE, 1'b0, 3'd0, 32'h0, T_IDLE);
        push(2, BASE, 1'b1, 3'd2, 32'h0, T_NSEQ);
        push(0, BASE + 32'h30, 1'b0, 3'd2, 32'h0, T_NSEQ);
        run_seq(span);
        rand_run(300);

        @(negedge hclk);
        use3 = 1'b1; cur_ws = 3;
        init_mem();
        push(0, BASE + 32'h10, 1'b0, 3'd2, 32'h0, T_NSEQ);
        run_seq(span);
        for (int k = 0; k < 4; k++)
            push(0, BASE + 32'h40 + 32'(4 * k), 1'b1, 3'd2, $urandom, (k == 0) ? T_NSEQ : T_SEQ);
        run_seq(span);
        check_eq("burst_span", 32'(span), 32'd16);
        for (int k = 0; k < 4; k++)
            push(0, BASE + 32'h40 + 32'(4 * k), 1'b0, 3'd2, 32'h0, (k == 0) ? T_NSEQ : T_SEQ);
        run_seq(span);
        error_cases();
        push(0, BASE + 32'h30, 1'b1, 3'd2, 32'h5A5A1234, T_NSEQ);
        push(0, BASE + 32'h30, 1'b0, 3'd2, 32'h0,        T_NSEQ);
        run_seq(span);
        reset_mid(BASE + 32'h30, 32'hCAFEF00D);
        push(1, BASE, 1'b0, 3'd0, 32'h0, T_IDLE);
        push(0, BASE + 32'h30, 1'b0, 3'd2, 32'h0, T_NSEQ);
        run_seq(span);
        rand_run(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
